// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: fetch vectors, next-PC select encodings,
// the NOP word and the interrupt-sequencing states.
package cpu_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pc_sel_t;

  typedef enum logic {
    IRQ_RUN     = 1'b0,
    IRQ_PENDING = 1'b1
  } irq_state_t;

  // Bit 31 is the supervisor flag; only redirects and vectors may change it.
  function automatic logic [31:0] pc_increment(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch stage, the hazard/decode logic and the
// instruction memory. The fetch stage is the master.
interface instruction_fetch_if;
  import cpu_pkg::*;

  logic        stall;
  pc_sel_t     pc_sel;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        irq;
  logic        exception;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] epc;
  logic        epc_valid;

  modport master (
    input  stall, pc_sel, branch_target, jump_target, jr_target,
           irq, exception, imem_data,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid,
           epc, epc_valid
  );

  modport slave (
    output stall, pc_sel, branch_target, jump_target, jr_target,
           irq, exception, imem_data,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid,
           epc, epc_valid
  );

endinterface

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register. Bubble wins over hold so a squash is never lost
// behind a stall; load captures the freshly fetched instruction.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_plus4_d,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr    <= NOP_WORD;
      pc_plus4 <= 32'h0000_0000;
      valid    <= 1'b0;
    end else if (bubble) begin
      instr    <= NOP_WORD;
      pc_plus4 <= 32'h0000_0000;
      valid    <= 1'b0;
    end else if (!hold && load) begin
      instr    <= instr_d;
      pc_plus4 <= pc_plus4_d;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, next-PC selection, interrupt/exception entry
// and the EPC capture; the IF/ID register lives in ifid_reg.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
)
(
  input logic                 clk,
  input logic                 reset,
  instruction_fetch_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_seq;
  logic [31:0] redirect_target;
  logic        redirect;

  irq_state_t  state;
  irq_state_t  state_next;
  logic        irq_eligible;
  logic        irq_take;

  logic [31:0] epc_q;
  logic [31:0] epc_next;
  logic        epc_load;
  logic        epc_valid_q;

  logic        ifid_hold;
  logic        ifid_bubble;
  logic        ifid_load;

  assign bus.imem_addr = pc;
  assign bus.epc       = epc_q;
  assign bus.epc_valid = epc_valid_q;

  assign pc_seq       = pc_increment(pc);
  assign redirect     = (bus.pc_sel != PC_SEQ);
  assign irq_eligible = bus.irq && !pc[31];

  always_comb begin
    redirect_target = pc_seq;
    case (bus.pc_sel)
      PC_BRANCH: redirect_target = bus.branch_target;
      PC_JUMP:   redirect_target = bus.jump_target;
      PC_JR:     redirect_target = bus.jr_target;
      default:   redirect_target = pc_seq;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IRQ_RUN;
    end else begin
      state <= state_next;
    end
  end

  // A request seen during a stall is parked in PENDING and taken on the
  // first unstalled cycle, even if irq has since dropped.
  always_comb begin
    state_next = state;
    irq_take   = 1'b0;
    if (bus.exception) begin
      state_next = IRQ_RUN;
    end else if (!bus.stall && ((state == IRQ_PENDING) || irq_eligible)) begin
      irq_take   = 1'b1;
      state_next = IRQ_RUN;
    end else if (bus.stall && (state == IRQ_RUN) && irq_eligible) begin
      state_next = IRQ_PENDING;
    end
  end

  always_comb begin
    pc_next     = pc;
    epc_next    = epc_q;
    epc_load    = 1'b0;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;
    if (bus.exception) begin
      pc_next     = EXC_VEC;
      epc_next    = bus.ifid_pc_plus4;
      epc_load    = 1'b1;
      ifid_bubble = 1'b1;
    end else if (irq_take) begin
      // Resume where the stream was heading, including a redirect this cycle.
      pc_next     = IRQ_VEC;
      epc_next    = redirect ? redirect_target : pc;
      epc_load    = 1'b1;
      ifid_bubble = 1'b1;
    end else if (bus.stall) begin
      ifid_hold   = 1'b1;
    end else if (redirect) begin
      pc_next     = redirect_target;
      ifid_bubble = 1'b1;
    end else begin
      pc_next     = pc_seq;
      ifid_load   = 1'b1;
    end
  end

  // epc_valid is registered so the pulse lines up with the updated epc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_VEC;
      epc_q       <= 32'h0000_0000;
      epc_valid_q <= 1'b0;
    end else begin
      pc          <= pc_next;
      epc_valid_q <= epc_load;
      if (epc_load) begin
        epc_q <= epc_next;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .hold       (ifid_hold),
    .bubble     (ifid_bubble),
    .load       (ifid_load),
    .instr_d    (bus.imem_data),
    .pc_plus4_d (pc_seq),
    .instr      (bus.ifid_instr),
    .pc_plus4   (bus.ifid_pc_plus4),
    .valid      (bus.ifid_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential fetch, redirects,
// stall, interrupt entry/masking/pending, exception priority and PC wrap.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] DATA_XOR = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  instruction_fetch_if bus();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: each word is its address with a fixed pattern.
  assign bus.imem_data = bus.imem_addr ^ DATA_XOR;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic stall_v, input pc_sel_t sel,
                                input logic [31:0] target, input logic irq_v,
                                input logic exc_v);
    bus.stall         = stall_v;
    bus.pc_sel        = sel;
    bus.branch_target = (sel == PC_BRANCH) ? target : 32'h0BAD_0B00;
    bus.jump_target   = (sel == PC_JUMP)   ? target : 32'h0BAD_0A00;
    bus.jr_target     = (sel == PC_JR)     ? target : 32'h0BAD_0C00;
    bus.irq           = irq_v;
    bus.exception     = exc_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset             = 1'b0;
    bus.stall         = 1'b0;
    bus.pc_sel        = PC_SEQ;
    bus.branch_target = 32'h0;
    bus.jump_target   = 32'h0;
    bus.jr_target     = 32'h0;
    bus.irq           = 1'b0;
    bus.exception     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset state");
    check_output("rst_pc", bus.imem_addr, 32'h8000_0000);
    check_output("rst_valid", {31'b0, bus.ifid_valid}, 32'h0);
    check_output("rst_instr", bus.ifid_instr, 32'h0);
    check_output("rst_pc4", bus.ifid_pc_plus4, 32'h0);
    check_output("rst_epc", bus.epc, 32'h0);
    check_output("rst_epcv", {31'b0, bus.epc_valid}, 32'h0);
    reset = 1'b1;
    check_output("rel_pc", bus.imem_addr, 32'h8000_0000);

    $display("[TB] sequential fetch");
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("seq1_pc", bus.imem_addr, 32'h8000_0004);
    check_output("seq1_pc4", bus.ifid_pc_plus4, 32'h8000_0004);
    check_output("seq1_instr", bus.ifid_instr, 32'h25A5_0000);
    check_output("seq1_valid", {31'b0, bus.ifid_valid}, 32'h1);
    check_output("seq1_epcv", {31'b0, bus.epc_valid}, 32'h0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("seq2_pc", bus.imem_addr, 32'h8000_0008);
    check_output("seq2_pc4", bus.ifid_pc_plus4, 32'h8000_0008);

    $display("[TB] redirects");
    apply_stimulus(1'b0, PC_JUMP, 32'h0000_0100, 1'b0, 1'b0);
    check_output("j100_pc", bus.imem_addr, 32'h0000_0100);
    check_output("j100_valid", {31'b0, bus.ifid_valid}, 32'h0);
    check_output("j100_instr", bus.ifid_instr, 32'h0);
    apply_stimulus(1'b0, PC_JUMP, 32'h0000_0040, 1'b0, 1'b0);
    check_output("j40_pc", bus.imem_addr, 32'h0000_0040);
    check_output("j40_valid", {31'b0, bus.ifid_valid}, 32'h0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("s44_pc", bus.imem_addr, 32'h0000_0044);
    check_output("s44_valid", {31'b0, bus.ifid_valid}, 32'h1);
    check_output("s44_pc4", bus.ifid_pc_plus4, 32'h0000_0044);
    check_output("s44_instr", bus.ifid_instr, 32'hA5A5_0040);
    apply_stimulus(1'b0, PC_BRANCH, 32'h0000_0500, 1'b0, 1'b0);
    check_output("br_pc", bus.imem_addr, 32'h0000_0500);
    apply_stimulus(1'b0, PC_JR, 32'h0000_0600, 1'b0, 1'b0);
    check_output("jr_pc", bus.imem_addr, 32'h0000_0600);
    check_output("jr_valid", {31'b0, bus.ifid_valid}, 32'h0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("s604_pc", bus.imem_addr, 32'h0000_0604);
    check_output("s604_instr", bus.ifid_instr, 32'hA5A5_0600);

    $display("[TB] stall ignores pc_sel");
    apply_stimulus(1'b1, PC_JUMP, 32'h0000_0900, 1'b0, 1'b0);
    check_output("stall_pc", bus.imem_addr, 32'h0000_0604);
    check_output("stall_pc4", bus.ifid_pc_plus4, 32'h0000_0604);
    check_output("stall_valid", {31'b0, bus.ifid_valid}, 32'h1);

    $display("[TB] interrupt pending across stall");
    apply_stimulus(1'b0, PC_JUMP, 32'h0000_0200, 1'b0, 1'b0);
    check_output("j200_pc", bus.imem_addr, 32'h0000_0200);
    apply_stimulus(1'b1, PC_SEQ, 32'h0, 1'b1, 1'b0);
    check_output("pend1_pc", bus.imem_addr, 32'h0000_0200);
    check_output("pend1_epcv", {31'b0, bus.epc_valid}, 32'h0);
    apply_stimulus(1'b1, PC_SEQ, 32'h0, 1'b1, 1'b0);
    check_output("pend2_pc", bus.imem_addr, 32'h0000_0200);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("acc_pc", bus.imem_addr, 32'h8000_0004);
    check_output("acc_epc", bus.epc, 32'h0000_0200);
    check_output("acc_epcv", {31'b0, bus.epc_valid}, 32'h1);
    check_output("acc_valid", {31'b0, bus.ifid_valid}, 32'h0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("post_pc", bus.imem_addr, 32'h8000_0008);
    check_output("post_epcv", {31'b0, bus.epc_valid}, 32'h0);
    check_output("post_epc", bus.epc, 32'h0000_0200);

    $display("[TB] irq masked in supervisor space");
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("sup_pc", bus.imem_addr, 32'h8000_0010);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b1, 1'b0);
    check_output("mask_pc", bus.imem_addr, 32'h8000_0014);
    check_output("mask_epcv", {31'b0, bus.epc_valid}, 32'h0);
    check_output("mask_valid", {31'b0, bus.ifid_valid}, 32'h1);

    $display("[TB] interrupt during redirect");
    apply_stimulus(1'b0, PC_JUMP, 32'h0000_0600, 1'b0, 1'b0);
    check_output("j600_pc", bus.imem_addr, 32'h0000_0600);
    apply_stimulus(1'b0, PC_BRANCH, 32'h0000_0700, 1'b1, 1'b0);
    check_output("accr_pc", bus.imem_addr, 32'h8000_0004);
    check_output("accr_epc", bus.epc, 32'h0000_0700);
    check_output("accr_epcv", {31'b0, bus.epc_valid}, 32'h1);

    $display("[TB] exception beats interrupt");
    apply_stimulus(1'b0, PC_JUMP, 32'h0000_0128, 1'b0, 1'b0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("s12c_pc4", bus.ifid_pc_plus4, 32'h0000_012C);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b1, 1'b1);
    check_output("exc_pc", bus.imem_addr, 32'h8000_0008);
    check_output("exc_epc", bus.epc, 32'h0000_012C);
    check_output("exc_epcv", {31'b0, bus.epc_valid}, 32'h1);
    check_output("exc_valid", {31'b0, bus.ifid_valid}, 32'h0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("pexc_pc", bus.imem_addr, 32'h8000_000C);
    check_output("pexc_epcv", {31'b0, bus.epc_valid}, 32'h0);

    $display("[TB] exception discards pending interrupt");
    apply_stimulus(1'b0, PC_JUMP, 32'h0000_0300, 1'b0, 1'b0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    apply_stimulus(1'b1, PC_SEQ, 32'h0, 1'b1, 1'b0);
    check_output("pend3_pc", bus.imem_addr, 32'h0000_0304);
    apply_stimulus(1'b1, PC_SEQ, 32'h0, 1'b0, 1'b1);
    check_output("excst_pc", bus.imem_addr, 32'h8000_0008);
    check_output("excst_epc", bus.epc, 32'h0000_0304);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("drop_pc", bus.imem_addr, 32'h8000_000C);
    check_output("drop_epcv", {31'b0, bus.epc_valid}, 32'h0);
    check_output("drop_pc4", bus.ifid_pc_plus4, 32'h8000_000C);

    $display("[TB] increment wrap keeps bit 31");
    apply_stimulus(1'b0, PC_JUMP, 32'h7FFF_FFFC, 1'b0, 1'b0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("wrap0_pc", bus.imem_addr, 32'h0000_0000);
    check_output("wrap0_pc4", bus.ifid_pc_plus4, 32'h0000_0000);
    apply_stimulus(1'b0, PC_JUMP, 32'hFFFF_FFFC, 1'b0, 1'b0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("wrap1_pc", bus.imem_addr, 32'h8000_0000);

    $display("[TB] reset while pending");
    apply_stimulus(1'b0, PC_JUMP, 32'h0000_0300, 1'b0, 1'b0);
    apply_stimulus(1'b1, PC_SEQ, 32'h0, 1'b1, 1'b0);
    bus.irq = 1'b0;
    reset   = 1'b0;
    #2;
    check_output("mrst_pc", bus.imem_addr, 32'h8000_0000);
    check_output("mrst_valid", {31'b0, bus.ifid_valid}, 32'h0);
    check_output("mrst_epc", bus.epc, 32'h0);
    reset = 1'b1;
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("mrel_pc", bus.imem_addr, 32'h8000_0004);
    check_output("mrel_valid", {31'b0, bus.ifid_valid}, 32'h1);
    check_output("mrel_pc4", bus.ifid_pc_plus4, 32'h8000_0004);
    check_output("mrel_epcv", {31'b0, bus.epc_valid}, 32'h0);
    apply_stimulus(1'b0, PC_SEQ, 32'h0, 1'b0, 1'b0);
    check_output("mrel2_pc", bus.imem_addr, 32'h8000_0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VEC, 32'h80000000, PC loaded at reset; supervisor bit 31 set.
REQ-002 Parameter IRQ_VEC, 32'h80000004, interrupt entry address.
REQ-003 Parameter EXC_VEC, 32'h80000008, exception entry address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low.
REQ-006 stall  input  1  hazard unit; hold PC and IF/ID register.
REQ-007 pc_sel  input  2  next-PC source: 0 sequential, 1 branch, 2 jump, 3 jr.
REQ-008 branch_target, jump_target, jr_target  input  32 each  redirect addresses, used verbatim.
REQ-009 irq  input  1  level-sensitive interrupt request.
REQ-010 exception  input  1  undefined instruction detected in ID.
REQ-011 imem_data  input  32  instruction word from instruction memory.
REQ-012 imem_addr  output  32  fetch address to instruction memory (= PC, combinational).
REQ-013 ifid_instr, ifid_pc_plus4  output  32 each  IF/ID pipeline register contents.
REQ-014 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-015 epc  output  32  return address for $k0 write; epc_valid  output  1  one-cycle pulse.

Function
REQ-016 Sequential increment SHALL be {PC[31], PC[30:0]+4}; bit 31 never changes by increment; wrap of bits 30:0 silent.
REQ-017 Priority per cycle SHALL be: exception > interrupt accept > stall > pc_sel redirect > sequential.
REQ-018 exception=1: PC<=EXC_VEC, IF/ID<=bubble, epc<=ifid_pc_plus4, epc_valid=1, regardless of stall.
REQ-019 Bubble SHALL mean ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0.
REQ-020 Interrupt FSM states RUN and PENDING; RUN->PENDING when irq=1, PC[31]=0, stall=1.
REQ-021 Interrupt accepted when (RUN, irq=1, PC[31]=0, stall=0) or (PENDING, stall=0): PC<=IRQ_VEC, IF/ID<=bubble, epc_valid=1, state->RUN.
REQ-022 On interrupt accept epc SHALL equal the address that would otherwise have been loaded into PC's successor instruction stream: redirect target if pc_sel!=0, else current PC.
REQ-023 PENDING SHALL return to RUN without accept if exception fires; irq is re-sampled later (masked while PC[31]=1).
REQ-024 stall=1 (no exception/accept): PC and IF/ID hold; pc_sel ignored (hazard unit re-presents it).
REQ-025 pc_sel!=0, no stall: PC<=selected target, IF/ID<=bubble (squash wrong-path fetch).
REQ-026 pc_sel=0, no stall: PC<=PC+4, ifid_instr<=imem_data, ifid_pc_plus4<=PC+4, ifid_valid<=1.
REQ-027 epc_valid SHALL be low in every cycle without exception or interrupt accept; epc holds last value.

Reset
REQ-028 reset low SHALL immediately force PC=RESET_VEC, IF/ID bubble, epc=0, epc_valid=0, state=RUN.
REQ-029 Reset asserted mid-stall or in PENDING SHALL discard pending interrupt; first fetch after release is RESET_VEC.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the three vectors, pc_sel encodings and NOP word constant.
REQ-031 IF/ID register SHALL be a sub-module ifid_reg (hold/bubble/load controls); PC and FSM stay in top.

Verification
REQ-032 Reset release, pc_sel=0, 3 cycles -> imem_addr 80000000,80000004,80000008; ifid_pc_plus4 80000004 after cycle 1.
REQ-033 PC=00000100, pc_sel=2, jump_target=00000040 -> next PC 00000040, ifid_valid=0 for one cycle.
REQ-034 PC=00000200, stall=1, irq=1 for 2 cycles then stall=0 -> PENDING held, then PC=80000004, epc=00000200, epc_valid pulse.
REQ-035 irq=1 while PC=80000010 -> no accept, PC=80000014, epc_valid=0.
REQ-036 exception=1 with irq=1, ifid_pc_plus4=0000012C -> PC=80000008, epc=0000012C, interrupt not taken that cycle.
REQ-037 reset pulsed low while stall=1 and PENDING -> PC=80000000, ifid_valid=0, state RUN.
